// File: rtl/stack_port_pkg.sv
// stack_port_pkg: shared definitions for the Forth core stack access engine.
//   - op_e     : stack operation encoding carried on i_OP
//   - REG_*    : register-file indices for the pointer write-back
//   - state_e  : sequencer states of stack_port
//   - helpers  : op decoding used by the engine and the bounds checker
package stack_port_pkg;

    typedef enum logic [1:0] {
        OP_PUSH_PS = 2'b00,
        OP_POP_PS  = 2'b01,
        OP_PUSH_RS = 2'b10,
        OP_POP_RS  = 2'b11
    } op_e;

    localparam logic [3:0] REG_PC  = 4'd0;
    localparam logic [3:0] REG_PSP = 4'd1;
    localparam logic [3:0] REG_RSP = 4'd2;
    localparam logic [3:0] REG_OFR = 4'd3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        MEM   = 3'd2,
        WB    = 3'd3,
        DONE  = 3'd4
    } state_e;

    // True for the two push encodings.
    function automatic logic op_is_push(input op_e op);
        return (op == OP_PUSH_PS) || (op == OP_PUSH_RS);
    endfunction

    // True when the operation targets the return stack.
    function automatic logic op_is_rs(input op_e op);
        return (op == OP_PUSH_RS) || (op == OP_POP_RS);
    endfunction

    // Register-file index of the pointer an operation updates.
    function automatic logic [3:0] op_reg(input op_e op);
        return op_is_rs(op) ? REG_RSP : REG_PSP;
    endfunction

endpackage

// File: rtl/stack_bounds_check.sv
// stack_bounds_check: combinational address / new-pointer / fault computation
// for one stack operation.
//
// Configuration macro: STACK_PORT_BOUNDS_EN
//   defined   : overflow/underflow detection, fault_o port present
//   undefined : plain 16-bit wrap arithmetic, no fault_o port
//
// Ports:
//   op_i       in  op_e  latched stack operation
//   ptr_i      in  16    latched stack pointer (next free slot)
//   addr_o     out 16    memory address to access (P for push, P-1 for pop)
//   new_ptr_o  out 16    pointer after the operation (P+1 / P-1)
//   fault_o    out 1     overflow/underflow (only with STACK_PORT_BOUNDS_EN)
module stack_bounds_check
    import stack_port_pkg::*;
#(
    parameter logic [15:0] PS_BASE = 16'd16,
    parameter logic [15:0] RS_BASE = 16'd48,
    parameter logic [15:0] RS_TOP  = 16'd56
) (
    input  op_e         op_i,
    input  logic [15:0] ptr_i,
    output logic [15:0] addr_o,
    output logic [15:0] new_ptr_o
`ifdef STACK_PORT_BOUNDS_EN
    ,
    output logic        fault_o
`endif
);

    // The return stack sits directly above the parameter stack; the limits
    // only make sense when the three bounds are strictly ordered.
    if (!((PS_BASE < RS_BASE) && (RS_BASE < RS_TOP))) begin : g_bad_params
        $error("stack_bounds_check: PS_BASE < RS_BASE < RS_TOP is required");
    end

    // Address and updated pointer; both wrap modulo 2^16.
    always_comb begin
        addr_o    = ptr_i;
        new_ptr_o = ptr_i;
        if (op_is_push(op_i)) begin
            addr_o    = ptr_i;
            new_ptr_o = ptr_i + 16'd1;
        end else begin
            addr_o    = ptr_i - 16'd1;
            new_ptr_o = ptr_i - 16'd1;
        end
    end

`ifdef STACK_PORT_BOUNDS_EN
    // Overflow when the slot to write is at or beyond the stack limit,
    // underflow when the stack is already at its empty value.
    always_comb begin
        fault_o = 1'b0;
        case (op_i)
            OP_PUSH_PS: fault_o = (ptr_i >= RS_BASE);
            OP_POP_PS:  fault_o = (ptr_i <= PS_BASE);
            OP_PUSH_RS: fault_o = (ptr_i >= RS_TOP);
            OP_POP_RS:  fault_o = (ptr_i <= RS_BASE);
            default:    fault_o = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/stack_port.sv
// stack_port: multi-cycle push/pop engine for the Forth core parameter stack
// (PSP, register 1) and return stack (RSP, register 2).
//
// Sequence: IDLE -(accept)-> CHECK -> MEM (req/ack) -> WB -> IDLE.
// With STACK_PORT_BOUNDS_EN defined, CHECK may instead go to DONE, which
// reports a fault without touching memory or the register file.
//
// Configuration macro: STACK_PORT_BOUNDS_EN (bounds checking and o_FAULT).
//
// Ports:
//   c_CLOCK     in  1   system clock, rising edge
//   c_RESETn    in  1   asynchronous active-low reset
//   i_REQ       in  1   operation request (ignored while busy)
//   i_OP        in  2   00 push PS, 01 pop PS, 10 push RS, 11 pop RS
//   i_PUSHDATA  in  16  data to push
//   i_PSP       in  16  current PSP from the register file
//   i_RSP       in  16  current RSP from the register file
//   o_BUSY      out 1   acceptance .. completion cycle inclusive
//   o_DONE      out 1   one-cycle completion pulse
//   o_FAULT     out 1   qualifies o_DONE: overflow/underflow, op aborted
//   o_POPDATA   out 16  last popped word
//   o_WADDR     out 4   register-file write address
//   o_WDATA     out 16  new pointer value
//   o_WRITE     out 1   register-file write strobe
//   o_MREQ      out 1   memory request
//   o_MWE       out 1   memory write enable (valid with o_MREQ)
//   o_MADDR     out 16  memory address
//   o_MDATA     out 16  memory write data
//   i_MACK      in  1   memory acknowledge, read data valid same cycle
//   i_MDATA     in  16  memory read data
module stack_port
    import stack_port_pkg::*;
#(
    parameter logic [15:0] PS_BASE = 16'd16,
    parameter logic [15:0] RS_BASE = 16'd48,
    parameter logic [15:0] RS_TOP  = 16'd56
) (
    input  logic        c_CLOCK,
    input  logic        c_RESETn,
    input  logic        i_REQ,
    input  logic [1:0]  i_OP,
    input  logic [15:0] i_PUSHDATA,
    input  logic [15:0] i_PSP,
    input  logic [15:0] i_RSP,
    output logic        o_BUSY,
    output logic        o_DONE,
    output logic        o_FAULT,
    output logic [15:0] o_POPDATA,
    output logic [3:0]  o_WADDR,
    output logic [15:0] o_WDATA,
    output logic        o_WRITE,
    output logic        o_MREQ,
    output logic        o_MWE,
    output logic [15:0] o_MADDR,
    output logic [15:0] o_MDATA,
    input  logic        i_MACK,
    input  logic [15:0] i_MDATA
);

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic [15:0] data_q, data_d;
    logic [15:0] ptr_q, ptr_d;
    logic [15:0] popdata_q, popdata_d;

    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        write_q, write_d;
    logic [3:0]  waddr_q, waddr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        mreq_q, mreq_d;
    logic        mwe_q, mwe_d;
    logic [15:0] maddr_q, maddr_d;
    logic [15:0] mdata_q, mdata_d;

    logic [15:0] addr_s;
    logic [15:0] new_ptr_s;

`ifdef STACK_PORT_BOUNDS_EN
    logic        fault_s;
    logic        fault_q, fault_d;
`endif

    // The checker works on the latched op/pointer, so its results are
    // stable from CHECK through WB.
    stack_bounds_check #(
        .PS_BASE (PS_BASE),
        .RS_BASE (RS_BASE),
        .RS_TOP  (RS_TOP)
    ) u_bounds (
        .op_i      (op_q),
        .ptr_i     (ptr_q),
        .addr_o    (addr_s),
        .new_ptr_o (new_ptr_s)
`ifdef STACK_PORT_BOUNDS_EN
        ,
        .fault_o   (fault_s)
`endif
    );

    // Next-state, operand latching and next values of the registered outputs.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        data_d    = data_q;
        ptr_d     = ptr_q;
        popdata_d = popdata_q;

        case (state_q)
            IDLE: begin
                if (i_REQ) begin
                    state_d = CHECK;
                    op_d    = op_e'(i_OP);
                    data_d  = i_PUSHDATA;
                    ptr_d   = op_is_rs(op_e'(i_OP)) ? i_RSP : i_PSP;
                end else begin
                    state_d = IDLE;
                end
            end
            CHECK: begin
`ifdef STACK_PORT_BOUNDS_EN
                if (fault_s) begin
                    state_d = DONE;
                end else begin
                    state_d = MEM;
                end
`else
                state_d = MEM;
`endif
            end
            MEM: begin
                if (i_MACK) begin
                    state_d = WB;
                    if (!op_is_push(op_q)) begin
                        popdata_d = i_MDATA;
                    end else begin
                        popdata_d = popdata_q;
                    end
                end else begin
                    state_d = MEM;
                end
            end
            WB: begin
                state_d = IDLE;
            end
`ifdef STACK_PORT_BOUNDS_EN
            DONE: begin
                state_d = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the state being entered so that they
        // come straight out of flops and clear asynchronously on reset.
        busy_d  = (state_d != IDLE);
        mreq_d  = (state_d == MEM);
        mwe_d   = mreq_d & op_is_push(op_q);
        maddr_d = mreq_d ? addr_s : 16'd0;
        mdata_d = mreq_d ? data_q : 16'd0;
        write_d = (state_d == WB);
        waddr_d = write_d ? op_reg(op_q) : 4'd0;
        wdata_d = write_d ? new_ptr_s : 16'd0;
`ifdef STACK_PORT_BOUNDS_EN
        done_d  = (state_d == WB) | (state_d == DONE);
        fault_d = (state_d == DONE);
`else
        done_d  = (state_d == WB);
`endif
    end

    // State, operand and output registers.
    always_ff @(posedge c_CLOCK or negedge c_RESETn) begin
        if (!c_RESETn) begin
            state_q   <= IDLE;
            op_q      <= OP_PUSH_PS;
            data_q    <= 16'd0;
            ptr_q     <= 16'd0;
            popdata_q <= 16'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            write_q   <= 1'b0;
            waddr_q   <= 4'd0;
            wdata_q   <= 16'd0;
            mreq_q    <= 1'b0;
            mwe_q     <= 1'b0;
            maddr_q   <= 16'd0;
            mdata_q   <= 16'd0;
`ifdef STACK_PORT_BOUNDS_EN
            fault_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            data_q    <= data_d;
            ptr_q     <= ptr_d;
            popdata_q <= popdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            write_q   <= write_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            mreq_q    <= mreq_d;
            mwe_q     <= mwe_d;
            maddr_q   <= maddr_d;
            mdata_q   <= mdata_d;
`ifdef STACK_PORT_BOUNDS_EN
            fault_q   <= fault_d;
`endif
        end
    end

    assign o_BUSY    = busy_q;
    assign o_DONE    = done_q;
    assign o_POPDATA = popdata_q;
    assign o_WADDR   = waddr_q;
    assign o_WDATA   = wdata_q;
    assign o_WRITE   = write_q;
    assign o_MREQ    = mreq_q;
    assign o_MWE     = mwe_q;
    assign o_MADDR   = maddr_q;
    assign o_MDATA   = mdata_q;
`ifdef STACK_PORT_BOUNDS_EN
    assign o_FAULT   = fault_q;
`else
    assign o_FAULT   = 1'b0;
`endif

endmodule

// File: tb/tb_stack_port.sv
// Self-checking bench for stack_port: a memory/register-file model owned by
// the bench drives the engine; a per-cycle compare process checks outputs.
module tb_stack_port;

    logic        c_CLOCK = 1'b0;
    logic        c_RESETn;
    logic        i_REQ;
    logic [1:0]  i_OP;
    logic [15:0] i_PUSHDATA, i_PSP, i_RSP;
    logic        o_BUSY, o_DONE, o_FAULT, o_WRITE, o_MREQ, o_MWE;
    logic [15:0] o_POPDATA, o_WDATA, o_MADDR, o_MDATA;
    logic [3:0]  o_WADDR;
    logic        i_MACK;
    logic [15:0] i_MDATA;

    stack_port dut (
        .c_CLOCK    (c_CLOCK),
        .c_RESETn   (c_RESETn),
        .i_REQ      (i_REQ),
        .i_OP       (i_OP),
        .i_PUSHDATA (i_PUSHDATA),
        .i_PSP      (i_PSP),
        .i_RSP      (i_RSP),
        .o_BUSY     (o_BUSY),
        .o_DONE     (o_DONE),
        .o_FAULT    (o_FAULT),
        .o_POPDATA  (o_POPDATA),
        .o_WADDR    (o_WADDR),
        .o_WDATA    (o_WDATA),
        .o_WRITE    (o_WRITE),
        .o_MREQ     (o_MREQ),
        .o_MWE      (o_MWE),
        .o_MADDR    (o_MADDR),
        .o_MDATA    (o_MDATA),
        .i_MACK     (i_MACK),
        .i_MDATA    (i_MDATA)
    );

    always #5 c_CLOCK = ~c_CLOCK;

    int n_tests = 0;
    int n_fail  = 0;

    // Environment model: data memory and the two stack pointers.
    logic [15:0] mem [0:65535];
    logic [15:0] psp_m, rsp_m;

    // Expected outputs for the current cycle.
    logic        chk_en;
    logic        e_busy, e_done, e_fault, e_write, e_mreq, e_mwe;
    logic [3:0]  e_waddr;
    logic [15:0] e_wdata, e_maddr, e_mdata, e_popdata;

    // Observations of the last operation.
    int          obs_cyc, obs_lat, obs_nmreq, obs_nwrite;
    logic [15:0] obs_maddr, obs_wdata;

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stack rules: the pointer names the next free slot; PS may hold
    // [16,48), RS may hold [48,56).
    function automatic logic model_fault(input logic [1:0] op, input logic [15:0] p);
`ifdef STACK_PORT_BOUNDS_EN
        case (op)
            2'b00:   return p >= 16'd48;
            2'b01:   return p <= 16'd16;
            2'b10:   return p >= 16'd56;
            default: return p <= 16'd48;
        endcase
`else
        return 1'b0;
`endif
    endfunction

    // Every-cycle comparison of the DUT against the expectations.
    always @(negedge c_CLOCK) begin
        if (chk_en) begin
            chk16("busy",    {15'd0, o_BUSY},  {15'd0, e_busy});
            chk16("done",    {15'd0, o_DONE},  {15'd0, e_done});
            chk16("fault",   {15'd0, o_FAULT}, {15'd0, e_fault});
            chk16("write",   {15'd0, o_WRITE}, {15'd0, e_write});
            chk16("mreq",    {15'd0, o_MREQ},  {15'd0, e_mreq});
            chk16("popdata", o_POPDATA, e_popdata);
            if (e_mreq) begin
                chk16("mwe",   {15'd0, o_MWE}, {15'd0, e_mwe});
                chk16("maddr", o_MADDR, e_maddr);
                if (e_mwe) chk16("mdata", o_MDATA, e_mdata);
            end
            if (e_write) begin
                chk16("waddr", {12'd0, o_WADDR}, {12'd0, e_waddr});
                chk16("wdata", o_WDATA, e_wdata);
            end
        end
    end

    task automatic set_idle();
        e_busy = 1'b0; e_done = 1'b0; e_fault = 1'b0;
        e_write = 1'b0; e_mreq = 1'b0; e_mwe = 1'b0;
    endtask

    // Advance to 1 time unit after the next rising edge and record outputs.
    task automatic step();
        @(posedge c_CLOCK);
        #1;
        obs_cyc++;
        if (o_DONE && obs_lat == 0) obs_lat = obs_cyc;
        if (o_MREQ) begin obs_nmreq++; obs_maddr = o_MADDR; end
        if (o_WRITE) begin obs_nwrite++; obs_wdata = o_WDATA; end
    endtask

    // One complete operation, entered and left in an IDLE cycle at edge+1.
    task automatic run_op(input logic [1:0] op, input logic [15:0] data,
                          input int waits, input bit hold);
        logic        push, rs, flt;
        logic [15:0] p, addr, newp, rd;
        push = ~op[0];
        rs   = op[1];
        p    = rs ? rsp_m : psp_m;
        addr = push ? p : p - 16'd1;
        newp = push ? p + 16'd1 : p - 16'd1;
        flt  = model_fault(op, p);
        rd   = mem[addr];
        obs_cyc = 0; obs_lat = 0; obs_nmreq = 0; obs_nwrite = 0;
        obs_maddr = 16'd0; obs_wdata = 16'd0;

        i_REQ = 1'b1; i_OP = op; i_PUSHDATA = data;
        i_PSP = psp_m; i_RSP = rsp_m; i_MACK = 1'b0;
        set_idle();

        step();
        i_REQ = hold; i_OP = 2'($urandom); i_PUSHDATA = 16'($urandom);
        e_busy = 1'b1;

        if (flt) begin
            step();
            e_done = 1'b1; e_fault = 1'b1;
        end else begin
            for (int k = 0; k <= waits; k++) begin
                step();
                e_mreq = 1'b1; e_mwe = push; e_maddr = addr; e_mdata = data;
                i_MACK  = (k == waits);
                i_MDATA = (k == waits) ? rd : 16'($urandom);
            end
            if (push) mem[addr] = data;
            step();
            i_MACK = 1'b0;
            e_mreq = 1'b0; e_write = 1'b1; e_done = 1'b1;
            e_waddr = rs ? 4'd2 : 4'd1; e_wdata = newp;
            if (!push) e_popdata = rd;
            if (rs) rsp_m = newp; else psp_m = newp;
        end

        step();
        set_idle();
        if (!hold) i_REQ = 1'b0;
        i_PSP = psp_m; i_RSP = rsp_m;
        chk_int("latency", obs_lat, flt ? 2 : 3 + waits);
    endtask

    initial begin
        c_RESETn = 1'b0; chk_en = 1'b0;
        i_REQ = 1'b0; i_OP = 2'b00; i_PUSHDATA = 16'd0;
        i_PSP = 16'd16; i_RSP = 16'd48; i_MACK = 1'b0; i_MDATA = 16'd0;
        psp_m = 16'd16; rsp_m = 16'd48;
        e_waddr = 4'd0; e_wdata = 16'd0; e_maddr = 16'd0; e_mdata = 16'd0;
        e_popdata = 16'd0;
        set_idle();
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);

        // Reset state.
        repeat (3) @(posedge c_CLOCK);
        #1;
        chk16("rst_busy",  {15'd0, o_BUSY},  16'd0);
        chk16("rst_done",  {15'd0, o_DONE},  16'd0);
        chk16("rst_fault", {15'd0, o_FAULT}, 16'd0);
        chk16("rst_write", {15'd0, o_WRITE}, 16'd0);
        chk16("rst_mreq",  {15'd0, o_MREQ},  16'd0);
        chk16("rst_mwe",   {15'd0, o_MWE},   16'd0);
        chk16("rst_pop",   o_POPDATA, 16'd0);
        chk16("rst_waddr", {12'd0, o_WADDR}, 16'd0);
        chk16("rst_wdata", o_WDATA, 16'd0);
        chk16("rst_maddr", o_MADDR, 16'd0);
        chk16("rst_mdata", o_MDATA, 16'd0);
        c_RESETn = 1'b1;
        chk_en = 1'b1;

        // Push PS 0xBEEF at PSP=16, zero-wait memory.
        psp_m = 16'd16;
        run_op(2'b00, 16'hBEEF, 0, 1'b0);
        chk16("push_maddr", obs_maddr, 16'd16);
        chk16("push_wdata", obs_wdata, 16'd17);
        chk_int("push_lat", obs_lat, 3);

        // Pop PS at PSP=17 with two wait cycles.
        run_op(2'b01, 16'h0000, 2, 1'b0);
        chk16("pop_maddr", obs_maddr, 16'd16);
        chk16("pop_wdata", obs_wdata, 16'd16);
        chk16("pop_data",  o_POPDATA, 16'hBEEF);
        chk_int("pop_lat", obs_lat, 5);

`ifdef STACK_PORT_BOUNDS_EN
        // Overflow of RS and underflow of PS.
        rsp_m = 16'd56;
        run_op(2'b10, 16'h1111, 0, 1'b0);
        chk_int("ovf_lat", obs_lat, 2);
        chk_int("ovf_mreq", obs_nmreq, 0);
        chk_int("ovf_write", obs_nwrite, 0);
        psp_m = 16'd16;
        run_op(2'b01, 16'h2222, 0, 1'b0);
        chk_int("unf_lat", obs_lat, 2);
        chk_int("unf_mreq", obs_nmreq, 0);
        chk_int("unf_write", obs_nwrite, 0);
        chk16("unf_pop", o_POPDATA, 16'hBEEF);
`else
        // Pop PS at PSP=0 wraps.
        psp_m = 16'd0;
        run_op(2'b01, 16'h0000, 0, 1'b0);
        chk16("wrap_maddr", obs_maddr, 16'hFFFF);
        chk16("wrap_wdata", obs_wdata, 16'hFFFF);
`endif

        // i_REQ held high: one access, next op accepted right after DONE.
        psp_m = 16'd20;
        run_op(2'b00, 16'h1234, 1, 1'b1);
        chk_int("hold_mreq", obs_nmreq, 2);
        chk_int("hold_write", obs_nwrite, 1);
        run_op(2'b01, 16'h0000, 0, 1'b0);
        chk_int("hold_lat2", obs_lat, 3);
        chk16("hold_pop", o_POPDATA, 16'h1234);

        // Reset in the middle of a memory access.
        i_REQ = 1'b1; i_OP = 2'b00; i_PUSHDATA = 16'h5555; i_PSP = psp_m;
        set_idle();
        obs_cyc = 0; obs_lat = 0; obs_nmreq = 0; obs_nwrite = 0;
        step();
        i_REQ = 1'b0; e_busy = 1'b1;
        step();
        chk_en = 1'b0;
        #2 c_RESETn = 1'b0;
        #1;
        chk16("rmid_mreq",  {15'd0, o_MREQ},  16'd0);
        chk16("rmid_busy",  {15'd0, o_BUSY},  16'd0);
        chk16("rmid_write", {15'd0, o_WRITE}, 16'd0);
        step();
        chk_int("rmid_nwrite", obs_nwrite, 0);
        c_RESETn = 1'b1;
        e_popdata = 16'd0;
        set_idle();
        chk_en = 1'b1;
        rsp_m = 16'd48;
        run_op(2'b10, 16'hCAFE, 0, 1'b0);
        chk16("post_rst_maddr", obs_maddr, 16'd48);
        chk16("post_rst_wdata", obs_wdata, 16'd49);

        // Randomized operations against the model.
        for (int n = 0; n < 200; n++) begin
            logic [1:0] op;
            int         w;
            bit         h;
            op = 2'($urandom_range(0, 3));
            w  = $urandom_range(0, 3);
            h  = (n != 199) && ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0) begin
`ifdef STACK_PORT_BOUNDS_EN
                psp_m = 16'($urandom_range(14, 50));
                rsp_m = 16'($urandom_range(46, 58));
`else
                psp_m = 16'($urandom_range(0, 2)) - 16'd1;
                rsp_m = 16'($urandom);
`endif
            end
            run_op(op, 16'($urandom), w, h);
        end

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
